bullet_pool: RTL and testbench

- Parametrised projectile manager replacing the per-bullet instances in the top-level VGA game.
- Owns N bullet slots and arbitrates fire requests from the shoot button into the lowest free slot.
- Advances active slots once per frame on `move`, retires slots on hit or on leaving the playfield top, and produces registered per-slot draw flags for the pixel mux.

---
 rtl/bullet_pool_if.sv | 36 +++
 rtl/bullet_pool.sv | 172 +++++++++++++++++
 tb/tb_bullet_pool.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_pool_if.sv
// ----------------------------------------------------------------------------
// bullet_pool_if : frame/pixel/fire/draw bundle between the game top and pool
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bullet_pool_if #(
  parameter int N_BULLETS = 3
);
  logic                 pixpulse;
  logic                 move;
  logic [9:0]           hcount;
  logic [9:0]           vcount;
  logic                 shoot;
  logic [9:0]           fire_x;
  logic [9:0]           fire_y;
  logic [N_BULLETS-1:0] hit_clear;
  logic [N_BULLETS-1:0] active;
  logic [3:0]           active_count;
  logic                 fire_ack;
  logic [2:0]           fire_slot;
  logic [N_BULLETS-1:0] draw_bullet;
  logic                 draw_any;

  modport master (
    output pixpulse, move, hcount, vcount, shoot, fire_x, fire_y, hit_clear,
    input  active, active_count, fire_ack, fire_slot, draw_bullet, draw_any
  );

  modport slave (
    input  pixpulse, move, hcount, vcount, shoot, fire_x, fire_y, hit_clear,
    output active, active_count, fire_ack, fire_slot, draw_bullet, draw_any
  );
endinterface

`default_nettype wire

// File: rtl/bullet_pool.sv
// ----------------------------------------------------------------------------
// bullet_pool : N-slot projectile manager with fire arbitration and pixel draw
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bullet_pool #(
  parameter int N_BULLETS = 3,
  parameter int SPEED     = 4,
  parameter int BUL_W     = 2,
  parameter int BUL_H     = 6,
  parameter int TOP_Y     = 0,
  parameter int COOLDOWN  = 8,
  parameter int AUTO_FIRE = 0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  bullet_pool_if.slave   bus
);

  localparam int          CD_W         = $clog2(COOLDOWN + 2);
  localparam logic [10:0] c_retire_lim = 11'(TOP_Y + SPEED);
  localparam logic [9:0]  c_speed      = 10'(SPEED);
  localparam logic [10:0] c_bul_w      = 11'(BUL_W);
  localparam logic [10:0] c_bul_h      = 11'(BUL_H);
  localparam logic [CD_W-1:0] c_cooldown = CD_W'(COOLDOWN);

  logic [N_BULLETS-1:0] r_active;
  logic [9:0]           r_x [N_BULLETS];
  logic [9:0]           r_y [N_BULLETS];
  logic [CD_W-1:0]      r_cooldown;
  logic                 r_fire_ack;
  logic [2:0]           r_fire_slot;
  logic [N_BULLETS-1:0] r_draw;
  logic                 r_draw_any;

  logic                 w_pending;
  logic                 w_y_ok;
  logic                 w_free_any;
  logic [2:0]           w_free_idx;
  logic                 w_accept;
  logic [N_BULLETS-1:0] w_hit;
  logic [3:0]           w_count;

  // Fire request source
  if (AUTO_FIRE != 0) begin : g_auto_fire
    assign w_pending = bus.shoot;
  end else begin : g_edge_fire
    logic r_shoot_q;
    logic r_pending;

    // The edge register tracks the button during reset so that a button held
    // through reset is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_shoot_q <= bus.shoot;
        r_pending <= 1'b0;
      end else begin
        r_shoot_q <= bus.shoot;
        if (bus.move) begin
          r_pending <= 1'b0;
        end else if (bus.shoot && !r_shoot_q) begin
          r_pending <= 1'b1;
        end
      end
    end

    assign w_pending = r_pending | (bus.shoot & ~r_shoot_q);
  end

  if (TOP_Y == 0) begin : g_top_zero
    assign w_y_ok = 1'b1;
  end else begin : g_top_bound
    assign w_y_ok = ({1'b0, bus.fire_y} >= 11'(TOP_Y));
  end

  // Lowest-index free slot: scan downward so the last hit wins
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = 3'd0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free_any = 1'b1;
        w_free_idx = 3'(i);
      end
    end
  end

  assign w_accept = bus.move & w_pending & (r_cooldown == '0) & w_free_any & w_y_ok;

  // Per-slot state: clear beats load/advance; only idle slots are loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      for (int i = 0; i < N_BULLETS; i++) begin
        r_x[i] <= 10'd0;
        r_y[i] <= 10'd0;
      end
    end else begin
      for (int i = 0; i < N_BULLETS; i++) begin
        if (bus.hit_clear[i] && r_active[i]) begin
          r_active[i] <= 1'b0;
        end else if (w_accept && (w_free_idx == 3'(i))) begin
          r_active[i] <= 1'b1;
          r_x[i]      <= bus.fire_x;
          r_y[i]      <= bus.fire_y;
        end else if (bus.move && r_active[i]) begin
          if ({1'b0, r_y[i]} < c_retire_lim) begin
            r_active[i] <= 1'b0;
          end else begin
            r_y[i] <= r_y[i] - c_speed;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cooldown  <= '0;
      r_fire_ack  <= 1'b0;
      r_fire_slot <= 3'd0;
    end else begin
      r_fire_ack <= w_accept;
      if (w_accept) begin
        r_cooldown  <= c_cooldown;
        r_fire_slot <= w_free_idx;
      end else if (bus.move && (r_cooldown != '0)) begin
        r_cooldown <= r_cooldown - 1'b1;
      end
    end
  end

  // Pixel hit test on 11-bit sums so right/bottom edges never wrap
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      w_hit[i] = r_active[i]
               & ({1'b0, bus.hcount} >= {1'b0, r_x[i]})
               & ({1'b0, bus.hcount} <  ({1'b0, r_x[i]} + c_bul_w))
               & ({1'b0, bus.vcount} >= {1'b0, r_y[i]})
               & ({1'b0, bus.vcount} <  ({1'b0, r_y[i]} + c_bul_h));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_draw     <= '0;
      r_draw_any <= 1'b0;
    end else if (bus.pixpulse) begin
      r_draw     <= w_hit;
      r_draw_any <= |w_hit;
    end
  end

  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < N_BULLETS; i++) begin
      w_count = w_count + {3'd0, r_active[i]};
    end
  end

  assign bus.active       = r_active;
  assign bus.active_count = w_count;
  assign bus.fire_ack     = r_fire_ack;
  assign bus.fire_slot    = r_fire_slot;
  assign bus.draw_bullet  = r_draw;
  assign bus.draw_any     = r_draw_any;

endmodule

`default_nettype wire

// File: tb/tb_bullet_pool.sv
// ----------------------------------------------------------------------------
// tb_bullet_pool : scoreboard bench for bullet_pool (COOLDOWN=8 and COOLDOWN=0)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bullet_pool;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bullet_pool_if #(.N_BULLETS(3)) ifa ();
  bullet_pool_if #(.N_BULLETS(3)) ifb ();

  bullet_pool #(.N_BULLETS(3), .COOLDOWN(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bullet_pool #(.N_BULLETS(3), .COOLDOWN(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [2:0] qa [$];
  logic [2:0] qb [$];
  logic [3:0] qd [$];
  logic       pix_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitors: fire acks and draw results are popped as the DUTs present them
  always @(posedge clk) pix_d <= ifa.pixpulse;

  always @(negedge clk) begin
    if (ifa.fire_ack === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL ack_a: got fire_ack slot %0d want no fire_ack", ifa.fire_slot);
      end else begin
        chk("fire_slot_a", 32'(ifa.fire_slot), 32'(qa.pop_front()));
      end
    end
    if (ifb.fire_ack === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL ack_b: got fire_ack slot %0d want no fire_ack", ifb.fire_slot);
      end else begin
        chk("fire_slot_b", 32'(ifb.fire_slot), 32'(qb.pop_front()));
      end
    end
    if (pix_d === 1'b1) begin
      if (qd.size() == 0) begin
        total++; bad++;
        $display("FAIL draw_a: got draw %0h with no expectation queued", {ifa.draw_any, ifa.draw_bullet});
      end else begin
        chk($sformatf("draw_a h=%0d v=%0d", ifa.hcount, ifa.vcount),
            32'({ifa.draw_any, ifa.draw_bullet}), 32'(qd.pop_front()));
      end
    end
  end

  task automatic cyc(input bit m, input logic [2:0] ha, input logic [2:0] hb);
    @(negedge clk);
    ifa.move = m; ifb.move = m;
    ifa.hit_clear = ha; ifb.hit_clear = hb;
    @(negedge clk);
    ifa.move = 1'b0; ifb.move = 1'b0;
    ifa.hit_clear = 3'b000; ifb.hit_clear = 3'b000;
  endtask

  task automatic mv();
    cyc(1'b1, 3'b000, 3'b000);
  endtask

  task automatic press(input bit a, input bit b, input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    ifa.fire_x = x; ifa.fire_y = y; ifb.fire_x = x; ifb.fire_y = y;
    ifa.shoot = a; ifb.shoot = b;
    @(negedge clk);
    ifa.shoot = 1'b0; ifb.shoot = 1'b0;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [3:0] e);
    @(negedge clk);
    ifa.hcount = h; ifa.vcount = v; ifa.pixpulse = 1'b1;
    qd.push_back(e);
    @(negedge clk);
    ifa.pixpulse = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    ifa.pixpulse = 0; ifa.move = 0; ifa.hcount = 0; ifa.vcount = 0;
    ifa.shoot = 1'b1; ifa.fire_x = 0; ifa.fire_y = 0; ifa.hit_clear = 0;
    ifb.pixpulse = 0; ifb.move = 0; ifb.hcount = 0; ifb.vcount = 0;
    ifb.shoot = 1'b1; ifb.fire_x = 0; ifb.fire_y = 0; ifb.hit_clear = 0;

    // 1: reset with shoot held high
    repeat (3) @(negedge clk);
    chk("rst active_a", 32'(ifa.active), 0);
    chk("rst count_a", 32'(ifa.active_count), 0);
    chk("rst ack_slot_a", 32'({ifa.fire_ack, ifa.fire_slot}), 0);
    chk("rst draw_a", 32'({ifa.draw_any, ifa.draw_bullet}), 0);
    chk("rst active_b", 32'(ifb.active), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mv();
    chk("held shoot active_a", 32'(ifa.active), 0);
    chk("held shoot active_b", 32'(ifb.active), 0);
    ifa.shoot = 1'b0; ifb.shoot = 1'b0;
    @(negedge clk);

    // 2: first fire into slot 0, then three moves
    press(1, 0, 10'd200, 10'd400);
    qa.push_back(3'd0);
    mv();
    chk("fire active_a", 32'(ifa.active), 32'b001);
    chk("fire count_a", 32'(ifa.active_count), 1);
    repeat (3) mv();
    pix(10'd200, 10'd388, 4'b1001);
    pix(10'd201, 10'd393, 4'b1001);
    pix(10'd200, 10'd387, 4'b0000);
    pix(10'd202, 10'd388, 4'b0000);
    pix(10'd200, 10'd394, 4'b0000);

    // 3: cooldown rejects, including the last blocked move
    press(1, 0, 10'd300, 10'd420);
    mv();
    chk("cooldown reject active_a", 32'(ifa.active), 32'b001);
    repeat (3) mv();
    press(1, 0, 10'd300, 10'd420);
    mv();
    chk("cooldown edge reject active_a", 32'(ifa.active), 32'b001);
    press(1, 0, 10'd300, 10'd420);
    qa.push_back(3'd1);
    mv();
    chk("cooldown accept active_a", 32'(ifa.active), 32'b011);
    chk("cooldown accept slot_a", 32'(ifa.fire_slot), 1);

    // 4: pool full with no cooldown
    for (int k = 0; k < 3; k++) begin
      press(0, 1, 10'd10, 10'd100);
      qb.push_back(3'(k));
      mv();
    end
    chk("full active_b", 32'(ifb.active), 32'b111);
    chk("full count_b", 32'(ifb.active_count), 3);
    press(0, 1, 10'd10, 10'd100);
    mv();
    chk("full reject active_b", 32'(ifb.active), 32'b111);
    chk("full reject slot_b holds", 32'(ifb.fire_slot), 2);
    cyc(1'b0, 3'b000, 3'b010);
    chk("hit active_b", 32'(ifb.active), 32'b101);
    chk("hit count_b", 32'(ifb.active_count), 2);
    press(0, 1, 10'd10, 10'd100);
    qb.push_back(3'd1);
    mv();
    chk("refill active_b", 32'(ifb.active), 32'b111);

    // 5: retire off the top, plain and together with hit_clear
    cyc(1'b0, 3'b000, 3'b111);
    chk("clear all active_b", 32'(ifb.active), 0);
    press(0, 1, 10'd50, 10'd9);
    qb.push_back(3'd0);
    mv();
    chk("spawn y9 active_b", 32'(ifb.active), 32'b001);
    mv();
    chk("y5 active_b", 32'(ifb.active), 32'b001);
    mv();
    chk("y1 active_b", 32'(ifb.active), 32'b001);
    mv();
    chk("retire active_b", 32'(ifb.active), 32'b000);
    press(0, 1, 10'd50, 10'd9);
    qb.push_back(3'd0);
    mv();
    mv();
    mv();
    cyc(1'b1, 3'b000, 3'b001);
    chk("hit+retire active_b", 32'(ifb.active), 32'b000);
    cyc(1'b0, 3'b000, 3'b100);
    mv();
    chk("after retire count_b", 32'(ifb.active_count), 0);

    // 6: draw window scan on a fresh slot 0 at (100,50)
    cyc(1'b0, 3'b011, 3'b000);
    chk("clear active_a", 32'(ifa.active), 0);
    repeat (8) mv();
    press(1, 0, 10'd100, 10'd50);
    qa.push_back(3'd0);
    mv();
    chk("draw spawn active_a", 32'(ifa.active), 32'b001);
    for (int v = 49; v <= 56; v++) begin
      for (int h = 99; h <= 102; h++) begin
        pix(10'(h), 10'(v), (h >= 100 && h <= 101 && v >= 50 && v <= 55) ? 4'b1001 : 4'b0000);
      end
    end

    // Reset mid-flight
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midflight rst active_a", 32'(ifa.active), 0);
    chk("midflight rst count_a", 32'(ifa.active_count), 0);
    chk("midflight rst draw_a", 32'({ifa.draw_any, ifa.draw_bullet}), 0);

    repeat (3) @(negedge clk);
    chk("pending acks a", 32'(qa.size()), 0);
    chk("pending acks b", 32'(qb.size()), 0);
    chk("pending draws", 32'(qd.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
